// File: rtl/exec_trace_buffer.sv
// Execution trace buffer: captures processor per-cycle outputs into a circular buffer,
// freezes POST_TRIG entries after a trigger, then replays the window oldest-first.
module exec_trace_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [15:0]       Instr,
    input  logic [3:0]        Flags,
    input  logic [7:0]        ALUResult,
    input  logic              PCSrc,
    input  logic              trig_br_en,
    input  logic              trig_op_en,
    input  logic [3:0]        trig_opcode,
    output logic [28:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state
);

    localparam int unsigned ENTRY_W = 29;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        READ  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic                rd_valid_q, rd_valid_d;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic                wr_en;
    logic [ENTRY_W-1:0]  wr_entry;
    logic                trig;
    logic [ADDR_W-1:0]   wr_ptr_inc;
    logic [CNT_W-1:0]    count_inc;
    logic [ADDR_W-1:0]   oldest_ptr;

    assign wr_entry   = {PCSrc, Flags, ALUResult, Instr};
    assign trig       = (trig_br_en & PCSrc) | (trig_op_en & (Instr[15:12] == trig_opcode));
    assign wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
    assign count_inc  = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
    // Oldest entry as seen after this cycle's write: wrapped buffer starts at the write pointer.
    assign oldest_ptr = (count_inc == CNT_W'(DEPTH)) ? wr_ptr_inc : '0;

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end
            end
            ARMED: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_inc;
                count_d  = count_inc;
                if (trig) begin
                    if (POST_TRIG == 0) begin
                        state_d  = READ;
                        rd_ptr_d = oldest_ptr;
                    end else begin
                        state_d    = POST;
                        post_cnt_d = ADDR_W'(POST_TRIG);
                    end
                end
            end
            POST: begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_inc;
                count_d    = count_inc;
                post_cnt_d = post_cnt_q - ADDR_W'(1);
                if (post_cnt_q == ADDR_W'(1)) begin
                    state_d  = READ;
                    rd_ptr_d = oldest_ptr;
                end
            end
            READ: begin
                if (rd_valid_q && rd_ready) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = (state_d == READ) && (count_d != '0);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Trace storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_data  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign state    = state_q;

endmodule
